// File: rtl/frame_scheduler.sv
// Frame pass sequencer: primes three line-buffer slots, then runs fetch/filter/store per output row.
// Requests are held until granted; a done coincident with grant is accepted, so a zero-latency engine costs one cycle per step.
module frame_scheduler #(
  parameter int ADDR_W = 32,
  parameter int DIM_W  = 10
) (
  input  logic              ahb_hclk,
  input  logic              n_rst,
  input  logic              start,
  input  logic [DIM_W-1:0]  cfg_width,
  input  logic [DIM_W-1:0]  cfg_height,
  input  logic [ADDR_W-1:0] cfg_rd_base,
  input  logic [ADDR_W-1:0] cfg_wr_base,
  input  logic [1:0]        cfg_filter,
  output logic              rd_req,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [DIM_W-1:0]  rd_len,
  output logic [1:0]        rd_slot,
  input  logic              rd_gnt,
  input  logic              rd_done,
  output logic              proc_start,
  output logic [1:0]        proc_top_slot,
  output logic [1:0]        proc_filter,
  input  logic              proc_done,
  output logic              wr_req,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DIM_W-1:0]  wr_len,
  input  logic              wr_gnt,
  input  logic              wr_done,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [3:0] {
    IDLE,
    CHECK,
    FETCH_REQ,
    FETCH_WAIT,
    PROC_REQ,
    PROC_WAIT,
    STORE_REQ,
    STORE_WAIT,
    FINISH
  } state_e;

  state_e            state_q, state_d;
  logic [DIM_W-1:0]  width_q, width_d;
  logic [DIM_W-1:0]  height_q, height_d;
  logic [ADDR_W-1:0] rd_base_q, rd_base_d;
  logic [ADDR_W-1:0] wr_base_q, wr_base_d;
  logic [1:0]        filter_q, filter_d;
  logic              err_q, err_d;
  logic [DIM_W-1:0]  fetch_row_q, fetch_row_d;
  logic [DIM_W-1:0]  out_row_q, out_row_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [1:0]        slot_q, slot_d;
  logic [1:0]        top_q, top_d;

  logic [DIM_W-1:0]  fetch_row_inc;
  logic [ADDR_W-1:0] row_stride;
  logic [1:0]        slot_nxt;
  logic [1:0]        top_nxt;
  logic              cfg_too_small;
  logic              last_row;

  assign fetch_row_inc = fetch_row_q + DIM_W'(1);
  assign row_stride    = ADDR_W'(width_q);
  assign slot_nxt      = (slot_q == 2'd2) ? 2'd0 : slot_q + 2'd1;
  assign top_nxt       = (top_q == 2'd2) ? 2'd0 : top_q + 2'd1;
  assign cfg_too_small = (width_q < DIM_W'(3)) || (height_q < DIM_W'(3));
  // Output rows run 1..height-2; borders are never stored.
  assign last_row      = (out_row_q == (height_q - DIM_W'(2)));

  always_comb begin
    state_d     = state_q;
    width_d     = width_q;
    height_d    = height_q;
    rd_base_d   = rd_base_q;
    wr_base_d   = wr_base_q;
    filter_d    = filter_q;
    err_d       = err_q;
    fetch_row_d = fetch_row_q;
    out_row_d   = out_row_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    slot_d      = slot_q;
    top_d       = top_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          width_d   = cfg_width;
          height_d  = cfg_height;
          rd_base_d = cfg_rd_base;
          wr_base_d = cfg_wr_base;
          filter_d  = cfg_filter;
          state_d   = CHECK;
        end
      end
      CHECK: begin
        if (cfg_too_small) begin
          err_d   = 1'b1;
          state_d = FINISH;
        end else begin
          err_d       = 1'b0;
          fetch_row_d = '0;
          out_row_d   = DIM_W'(1);
          rd_ptr_d    = rd_base_q;
          wr_ptr_d    = wr_base_q + row_stride;
          slot_d      = 2'd0;
          top_d       = 2'd0;
          state_d     = FETCH_REQ;
        end
      end
      FETCH_REQ: begin
        if (rd_gnt) begin
          rd_ptr_d    = rd_ptr_q + row_stride;
          slot_d      = slot_nxt;
          fetch_row_d = fetch_row_inc;
          if (!rd_done) begin
            state_d = FETCH_WAIT;
          end else if (fetch_row_inc < DIM_W'(3)) begin
            state_d = FETCH_REQ;
          end else begin
            state_d = PROC_REQ;
          end
        end
      end
      FETCH_WAIT: begin
        if (rd_done) begin
          state_d = (fetch_row_q < DIM_W'(3)) ? FETCH_REQ : PROC_REQ;
        end
      end
      PROC_REQ: begin
        state_d = PROC_WAIT;
      end
      PROC_WAIT: begin
        if (proc_done) begin
          state_d = STORE_REQ;
        end
      end
      STORE_REQ: begin
        if (wr_gnt) begin
          wr_ptr_d = wr_ptr_q + row_stride;
          if (!wr_done) begin
            state_d = STORE_WAIT;
          end else if (last_row) begin
            state_d = FINISH;
          end else begin
            out_row_d = out_row_q + DIM_W'(1);
            top_d     = top_nxt;
            state_d   = FETCH_REQ;
          end
        end
      end
      STORE_WAIT: begin
        if (wr_done) begin
          if (last_row) begin
            state_d = FINISH;
          end else begin
            out_row_d = out_row_q + DIM_W'(1);
            top_d     = top_nxt;
            state_d   = FETCH_REQ;
          end
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge ahb_hclk) begin
    if (n_rst) begin
      state_q     <= IDLE;
      width_q     <= '0;
      height_q    <= '0;
      rd_base_q   <= '0;
      wr_base_q   <= '0;
      filter_q    <= '0;
      err_q       <= 1'b0;
      fetch_row_q <= '0;
      out_row_q   <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      slot_q      <= '0;
      top_q       <= '0;
    end else begin
      state_q     <= state_d;
      width_q     <= width_d;
      height_q    <= height_d;
      rd_base_q   <= rd_base_d;
      wr_base_q   <= wr_base_d;
      filter_q    <= filter_d;
      err_q       <= err_d;
      fetch_row_q <= fetch_row_d;
      out_row_q   <= out_row_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      slot_q      <= slot_d;
      top_q       <= top_d;
    end
  end

  // All outputs decode straight from registers so they are glitch-free and zero out of reset.
  assign rd_req        = (state_q == FETCH_REQ);
  assign rd_addr       = rd_ptr_q;
  assign rd_len        = width_q;
  assign rd_slot       = slot_q;
  assign proc_start    = (state_q == PROC_REQ);
  assign proc_top_slot = top_q;
  assign proc_filter   = filter_q;
  assign wr_req        = (state_q == STORE_REQ);
  assign wr_addr       = wr_ptr_q;
  assign wr_len        = width_q;
  assign busy          = (state_q != IDLE);
  assign done          = (state_q == FINISH);
  assign err           = err_q;

endmodule

// File: tb/tb_frame_scheduler.sv
// Directed bench for frame_scheduler with behavioural read/filter/write engines.
module tb_frame_scheduler;
  localparam int AW = 32;
  localparam int DW = 10;

  localparam logic [31:0] E_RD  [4] = '{32'h1000, 32'h1008, 32'h1010, 32'h1018};
  localparam logic [1:0]  E_SL  [4] = '{2'd0, 2'd1, 2'd2, 2'd0};
  localparam logic [1:0]  E_TOP [2] = '{2'd0, 2'd1};
  localparam logic [31:0] E_WR  [2] = '{32'h2008, 32'h2010};

  logic          clk;
  logic          n_rst, start;
  logic [DW-1:0] cfg_width, cfg_height;
  logic [AW-1:0] cfg_rd_base, cfg_wr_base;
  logic [1:0]    cfg_filter;
  logic          rd_req, rd_gnt, rd_done;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_len;
  logic [1:0]    rd_slot;
  logic          proc_start, proc_done;
  logic [1:0]    proc_top_slot, proc_filter;
  logic          wr_req, wr_gnt, wr_done;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_len;
  logic          busy, done, err;

  int  rd_gl, rd_dl, wr_gl, wr_dl, pr_lat;
  bit  rd_hold, stray_en;
  int  pass_cnt, total_cnt;

  logic [31:0] rd_aq[$];
  logic [1:0]  rd_sq[$];
  logic [1:0]  top_q[$];
  logic [1:0]  pf_q[$];
  logic [31:0] wr_aq[$];
  int          rd_req_cyc, wr_req_cyc, busy_cyc, done_cnt;

  frame_scheduler #(.ADDR_W(AW), .DIM_W(DW)) dut (
    .ahb_hclk(clk), .n_rst(n_rst), .start(start),
    .cfg_width(cfg_width), .cfg_height(cfg_height),
    .cfg_rd_base(cfg_rd_base), .cfg_wr_base(cfg_wr_base), .cfg_filter(cfg_filter),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_len(rd_len), .rd_slot(rd_slot),
    .rd_gnt(rd_gnt), .rd_done(rd_done),
    .proc_start(proc_start), .proc_top_slot(proc_top_slot), .proc_filter(proc_filter),
    .proc_done(proc_done),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_len(wr_len), .wr_gnt(wr_gnt), .wr_done(wr_done),
    .busy(busy), .done(done), .err(err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Engine models drive at posedge+1; test tasks drive at posedge+2; sampling at negedge.
  initial begin : engines
    int rc, wc, pc;
    bit rg, wg, pb;
    rc = 0; wc = 0; pc = 0; rg = 0; wg = 0; pb = 0;
    rd_gnt = 0; rd_done = 0; wr_gnt = 0; wr_done = 0; proc_done = 0;
    forever begin
      @(posedge clk); #1;
      rd_gnt = 0; rd_done = 0; wr_gnt = 0; wr_done = 0; proc_done = 0;
      if (n_rst) begin
        rc = 0; wc = 0; pc = 0; rg = 0; wg = 0; pb = 0;
      end else begin
        if (rg) begin
          rc++;
          if (stray_en) proc_done = 1;
          if (rc >= rd_dl) begin rd_done = 1; rg = 0; rc = 0; end
        end else if (rd_req && !rd_hold) begin
          if (rc >= rd_gl) begin
            rd_gnt = 1; rc = 0;
            if (rd_dl == 0) rd_done = 1; else rg = 1;
          end else rc++;
        end
        if (wg) begin
          wc++;
          if (wc >= wr_dl) begin wr_done = 1; wg = 0; wc = 0; end
        end else if (wr_req) begin
          if (wc >= wr_gl) begin
            wr_gnt = 1; wc = 0;
            if (wr_dl == 0) wr_done = 1; else wg = 1;
          end else wc++;
        end
        if (pb) begin
          pc++;
          if (pc >= pr_lat) begin proc_done = 1; pb = 0; pc = 0; end
        end else if (proc_start) begin
          pb = 1; pc = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rd_req) rd_req_cyc++;
    if (wr_req) wr_req_cyc++;
    if (busy) busy_cyc++;
    if (done) done_cnt++;
    if (rd_req && rd_gnt) begin rd_aq.push_back(rd_addr); rd_sq.push_back(rd_slot); end
    if (proc_start) begin top_q.push_back(proc_top_slot); pf_q.push_back(proc_filter); end
    if (wr_req && wr_gnt) wr_aq.push_back(wr_addr);
  end

  task automatic pulse_start(input logic [DW-1:0] w, input logic [DW-1:0] h,
                             input logic [AW-1:0] rb, input logic [AW-1:0] wb,
                             input logic [1:0] f);
    @(posedge clk); #2;
    cfg_width = w; cfg_height = h; cfg_rd_base = rb; cfg_wr_base = wb; cfg_filter = f;
    start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
  endtask

  task automatic wait_done(input int maxc, output bit ok);
    int c0;
    c0 = done_cnt;
    ok = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      @(posedge clk);
      if (done_cnt != c0) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    n_rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total_cnt++;
    if ({rd_req, wr_req, proc_start, busy, done, err} !== 6'b0)
      $display("FAIL reset_ctrl: got %b want 000000", {rd_req, wr_req, proc_start, busy, done, err});
    else pass_cnt++;
    total_cnt++;
    if (rd_addr !== 32'h0 || wr_addr !== 32'h0)
      $display("FAIL reset_addr: got rd=%h wr=%h want 0", rd_addr, wr_addr);
    else pass_cnt++;
    total_cnt++;
    if ({rd_len, wr_len, rd_slot, proc_top_slot, proc_filter} !== 26'h0)
      $display("FAIL reset_misc: got %h want 0", {rd_len, wr_len, rd_slot, proc_top_slot, proc_filter});
    else pass_cnt++;
    @(posedge clk); #2;
    n_rst = 1'b0;
  endtask

  task automatic test_basic();
    int r0, p0, w0, d0;
    bit ok;
    rd_gl = 2; rd_dl = 2; wr_gl = 2; wr_dl = 2; pr_lat = 2;
    r0 = rd_aq.size(); p0 = top_q.size(); w0 = wr_aq.size(); d0 = done_cnt;
    pulse_start(10'd8, 10'd4, 32'h1000, 32'h2000, 2'd2);
    cfg_width = 10'd5; cfg_height = 10'd9; cfg_rd_base = 32'h7000; cfg_filter = 2'd1;
    wait_done(400, ok);
    total_cnt++;
    if (!ok) $display("FAIL basic_done: no done pulse within 400 cycles");
    else pass_cnt++;
    total_cnt++;
    if (rd_aq.size() - r0 != 4 || top_q.size() - p0 != 2 || wr_aq.size() - w0 != 2)
      $display("FAIL basic_counts: got rd=%0d proc=%0d wr=%0d want 4/2/2",
               rd_aq.size() - r0, top_q.size() - p0, wr_aq.size() - w0);
    else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      total_cnt++;
      if (r0 + i >= rd_aq.size()) $display("FAIL basic_fetch%0d: missing, want %h/s%0d", i, E_RD[i], E_SL[i]);
      else if (rd_aq[r0+i] !== E_RD[i] || rd_sq[r0+i] !== E_SL[i])
        $display("FAIL basic_fetch%0d: got %h/s%0d want %h/s%0d", i, rd_aq[r0+i], rd_sq[r0+i], E_RD[i], E_SL[i]);
      else pass_cnt++;
    end
    for (int i = 0; i < 2; i++) begin
      total_cnt++;
      if (p0 + i >= top_q.size() || w0 + i >= wr_aq.size())
        $display("FAIL basic_row%0d: missing proc/store", i);
      else if (top_q[p0+i] !== E_TOP[i] || pf_q[p0+i] !== 2'd2 || wr_aq[w0+i] !== E_WR[i])
        $display("FAIL basic_row%0d: got top=%0d filt=%0d wr=%h want top=%0d filt=2 wr=%h",
                 i, top_q[p0+i], pf_q[p0+i], wr_aq[w0+i], E_TOP[i], E_WR[i]);
      else pass_cnt++;
    end
    @(negedge clk);
    total_cnt++;
    if (err !== 1'b0 || busy !== 1'b0 || done_cnt - d0 != 1)
      $display("FAIL basic_end: got err=%b busy=%b dones=%0d want 0/0/1", err, busy, done_cnt - d0);
    else pass_cnt++;
  endtask

  task automatic test_min_frame();
    int r0, p0, w0;
    bit ok;
    logic [31:0] e_rd [3];
    e_rd = '{32'h100, 32'h103, 32'h106};
    r0 = rd_aq.size(); p0 = top_q.size(); w0 = wr_aq.size();
    pulse_start(10'd3, 10'd3, 32'h100, 32'h200, 2'd0);
    wait_done(300, ok);
    total_cnt++;
    if (!ok || rd_aq.size() - r0 != 3 || top_q.size() - p0 != 1 || wr_aq.size() - w0 != 1)
      $display("FAIL min_counts: got done=%b rd=%0d proc=%0d wr=%0d want 1 3/1/1",
               ok, rd_aq.size() - r0, top_q.size() - p0, wr_aq.size() - w0);
    else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      total_cnt++;
      if (r0 + i >= rd_aq.size()) $display("FAIL min_fetch%0d: missing, want %h", i, e_rd[i]);
      else if (rd_aq[r0+i] !== e_rd[i] || rd_sq[r0+i] !== 2'(i))
        $display("FAIL min_fetch%0d: got %h/s%0d want %h/s%0d", i, rd_aq[r0+i], rd_sq[r0+i], e_rd[i], i);
      else pass_cnt++;
    end
    total_cnt++;
    if (p0 >= top_q.size() || w0 >= wr_aq.size()) $display("FAIL min_store: missing proc/store");
    else if (top_q[p0] !== 2'd0 || wr_aq[w0] !== 32'h203)
      $display("FAIL min_store: got top=%0d wr=%h want top=0 wr=00000203", top_q[p0], wr_aq[w0]);
    else pass_cnt++;
  endtask

  task automatic test_invalid_cfg();
    int rq0, wq0, p0;
    bit ok;
    rq0 = rd_req_cyc; wq0 = wr_req_cyc; p0 = top_q.size();
    pulse_start(10'd2, 10'd100, 32'h3000, 32'h4000, 2'd1);
    @(negedge clk);
    total_cnt++;
    if (busy !== 1'b1 || done !== 1'b0)
      $display("FAIL inv_check_cycle: got busy=%b done=%b want 1/0", busy, done);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (done !== 1'b1 || err !== 1'b1)
      $display("FAIL inv_finish: got done=%b err=%b want 1/1", done, err);
    else pass_cnt++;
    repeat (3) @(negedge clk);
    total_cnt++;
    if (busy !== 1'b0 || rd_req_cyc != rq0 || wr_req_cyc != wq0 || top_q.size() != p0)
      $display("FAIL inv_no_txn: got busy=%b rd=%0d wr=%0d proc=%0d want 0/0/0/0",
               busy, rd_req_cyc - rq0, wr_req_cyc - wq0, top_q.size() - p0);
    else pass_cnt++;
    total_cnt++;
    if (err !== 1'b1) $display("FAIL inv_err_sticky: got err=%b want 1", err);
    else pass_cnt++;
    pulse_start(10'd3, 10'd3, 32'h0, 32'h0, 2'd0);
    wait_done(300, ok);
    @(negedge clk);
    total_cnt++;
    if (!ok || err !== 1'b0) $display("FAIL inv_err_clear: got done=%b err=%b want 1/0", ok, err);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int r0, p0, w0, rq0, wq0, b0;
    bit ok;
    rd_gl = 0; rd_dl = 0; wr_gl = 0; wr_dl = 0; pr_lat = 1;
    r0 = rd_aq.size(); p0 = top_q.size(); w0 = wr_aq.size();
    rq0 = rd_req_cyc; wq0 = wr_req_cyc; b0 = busy_cyc;
    pulse_start(10'd8, 10'd4, 32'h1000, 32'h2000, 2'd1);
    wait_done(200, ok);
    @(negedge clk);
    total_cnt++;
    if (!ok || rd_req_cyc - rq0 != 4 || wr_req_cyc - wq0 != 2)
      $display("FAIL b2b_req_cycles: got done=%b rd=%0d wr=%0d want 1 4/2", ok, rd_req_cyc - rq0, wr_req_cyc - wq0);
    else pass_cnt++;
    // CHECK + 3 fetches + 2x(proc req/wait + store) + 1 fetch + FINISH
    total_cnt++;
    if (busy_cyc - b0 != 12) $display("FAIL b2b_busy_cycles: got %0d want 12", busy_cyc - b0);
    else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      total_cnt++;
      if (r0 + i >= rd_aq.size()) $display("FAIL b2b_fetch%0d: missing, want %h", i, E_RD[i]);
      else if (rd_aq[r0+i] !== E_RD[i] || rd_sq[r0+i] !== E_SL[i])
        $display("FAIL b2b_fetch%0d: got %h/s%0d want %h/s%0d", i, rd_aq[r0+i], rd_sq[r0+i], E_RD[i], E_SL[i]);
      else pass_cnt++;
    end
    for (int i = 0; i < 2; i++) begin
      total_cnt++;
      if (p0 + i >= top_q.size() || w0 + i >= wr_aq.size()) $display("FAIL b2b_row%0d: missing proc/store", i);
      else if (top_q[p0+i] !== E_TOP[i] || pf_q[p0+i] !== 2'd1 || wr_aq[w0+i] !== E_WR[i])
        $display("FAIL b2b_row%0d: got top=%0d filt=%0d wr=%h want top=%0d filt=1 wr=%h",
                 i, top_q[p0+i], pf_q[p0+i], wr_aq[w0+i], E_TOP[i], E_WR[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_backpressure();
    int r0, p0, w0, d0, rq_end;
    bit ok, seen, stable;
    rd_gl = 2; rd_dl = 3; wr_gl = 1; wr_dl = 2; pr_lat = 2;
    rd_hold = 1'b1;
    r0 = rd_aq.size(); p0 = top_q.size(); w0 = wr_aq.size(); d0 = done_cnt;
    pulse_start(10'd8, 10'd4, 32'h1000, 32'h2000, 2'd3);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rd_req) begin seen = 1'b1; break; end
    end
    total_cnt++;
    if (!seen) $display("FAIL bp_req_seen: rd_req never rose within 10 cycles");
    else pass_cnt++;
    stable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (rd_req !== 1'b1 || rd_addr !== 32'h1000 || rd_slot !== 2'd0 || rd_len !== 10'd8) stable = 1'b0;
      if (i == 5) begin
        cfg_width = 10'd20; cfg_height = 10'd30; cfg_rd_base = 32'h9000; start = 1'b1;
      end
      if (i == 6) start = 1'b0;
      @(negedge clk);
    end
    total_cnt++;
    if (!stable)
      $display("FAIL bp_hold_stable: got req=%b addr=%h slot=%0d len=%0d want 1/00001000/0/8",
               rd_req, rd_addr, rd_slot, rd_len);
    else pass_cnt++;
    stray_en = 1'b1;
    rd_hold = 1'b0;
    wait_done(500, ok);
    stray_en = 1'b0;
    total_cnt++;
    if (!ok || rd_aq.size() - r0 != 4 || top_q.size() - p0 != 2 || wr_aq.size() - w0 != 2)
      $display("FAIL bp_counts: got done=%b rd=%0d proc=%0d wr=%0d want 1 4/2/2",
               ok, rd_aq.size() - r0, top_q.size() - p0, wr_aq.size() - w0);
    else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      total_cnt++;
      if (r0 + i >= rd_aq.size()) $display("FAIL bp_fetch%0d: missing, want %h", i, E_RD[i]);
      else if (rd_aq[r0+i] !== E_RD[i] || rd_sq[r0+i] !== E_SL[i])
        $display("FAIL bp_fetch%0d: got %h/s%0d want %h/s%0d", i, rd_aq[r0+i], rd_sq[r0+i], E_RD[i], E_SL[i]);
      else pass_cnt++;
    end
    total_cnt++;
    if (w0 + 1 >= wr_aq.size() || p0 + 1 >= top_q.size()) $display("FAIL bp_rows: missing proc/store");
    else if (wr_aq[w0] !== E_WR[0] || wr_aq[w0+1] !== E_WR[1] || top_q[p0+1] !== 2'd1 || pf_q[p0] !== 2'd3)
      $display("FAIL bp_rows: got wr=%h,%h top1=%0d filt=%0d want 00002008,00002010 1 3",
               wr_aq[w0], wr_aq[w0+1], top_q[p0+1], pf_q[p0]);
    else pass_cnt++;
    rq_end = rd_req_cyc;
    repeat (6) @(negedge clk);
    total_cnt++;
    if (busy !== 1'b0 || rd_req_cyc != rq_end || done_cnt - d0 != 1)
      $display("FAIL bp_no_restart: got busy=%b extra_rd=%0d dones=%0d want 0/0/1",
               busy, rd_req_cyc - rq_end, done_cnt - d0);
    else pass_cnt++;
  endtask

  task automatic test_reset_midpass();
    int r0, p0, w0, rq0;
    bit ok, seen;
    logic [31:0] e_rd [3];
    e_rd = '{32'h5000, 32'h5003, 32'h5006};
    rd_gl = 1; rd_dl = 1; wr_gl = 1; wr_dl = 1; pr_lat = 4;
    p0 = top_q.size();
    pulse_start(10'd8, 10'd6, 32'h1000, 32'h2000, 2'd3);
    seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      if (top_q.size() - p0 >= 2) begin seen = 1'b1; break; end
    end
    total_cnt++;
    if (!seen) $display("FAIL rst_mid_reach: second proc_start not seen within 300 cycles");
    else pass_cnt++;
    #2 n_rst = 1'b1;
    @(posedge clk); #2;
    n_rst = 1'b0;
    @(negedge clk);
    total_cnt++;
    if ({rd_req, wr_req, proc_start, busy, done, err} !== 6'b0 || proc_filter !== 2'd0 || proc_top_slot !== 2'd0)
      $display("FAIL rst_mid_outputs: got ctrl=%b filt=%0d top=%0d want 000000/0/0",
               {rd_req, wr_req, proc_start, busy, done, err}, proc_filter, proc_top_slot);
    else pass_cnt++;
    total_cnt++;
    if (rd_addr !== 32'h0 || wr_addr !== 32'h0 || rd_slot !== 2'd0 || rd_len !== 10'd0)
      $display("FAIL rst_mid_data: got rd=%h wr=%h slot=%0d len=%0d want 0", rd_addr, wr_addr, rd_slot, rd_len);
    else pass_cnt++;
    rq0 = rd_req_cyc; p0 = top_q.size(); w0 = wr_aq.size();
    repeat (8) @(negedge clk);
    total_cnt++;
    if (rd_req_cyc != rq0 || top_q.size() != p0 || wr_aq.size() != w0 || busy !== 1'b0)
      $display("FAIL rst_mid_quiet: got rd=%0d proc=%0d wr=%0d busy=%b want 0/0/0/0",
               rd_req_cyc - rq0, top_q.size() - p0, wr_aq.size() - w0, busy);
    else pass_cnt++;
    r0 = rd_aq.size();
    pulse_start(10'd3, 10'd3, 32'h5000, 32'h6000, 2'd0);
    wait_done(300, ok);
    total_cnt++;
    if (!ok || rd_aq.size() - r0 != 3 || top_q.size() - p0 != 1 || wr_aq.size() - w0 != 1)
      $display("FAIL rst_replay_counts: got done=%b rd=%0d proc=%0d wr=%0d want 1 3/1/1",
               ok, rd_aq.size() - r0, top_q.size() - p0, wr_aq.size() - w0);
    else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      total_cnt++;
      if (r0 + i >= rd_aq.size()) $display("FAIL rst_replay_fetch%0d: missing, want %h", i, e_rd[i]);
      else if (rd_aq[r0+i] !== e_rd[i] || rd_sq[r0+i] !== 2'(i))
        $display("FAIL rst_replay_fetch%0d: got %h/s%0d want %h/s%0d", i, rd_aq[r0+i], rd_sq[r0+i], e_rd[i], i);
      else pass_cnt++;
    end
    total_cnt++;
    if (p0 >= top_q.size() || w0 >= wr_aq.size()) $display("FAIL rst_replay_store: missing proc/store");
    else if (top_q[p0] !== 2'd0 || wr_aq[w0] !== 32'h6003)
      $display("FAIL rst_replay_store: got top=%0d wr=%h want 0/00006003", top_q[p0], wr_aq[w0]);
    else pass_cnt++;
  endtask

  initial begin
    pass_cnt = 0; total_cnt = 0;
    rd_req_cyc = 0; wr_req_cyc = 0; busy_cyc = 0; done_cnt = 0;
    rd_gl = 2; rd_dl = 2; wr_gl = 2; wr_dl = 2; pr_lat = 2;
    rd_hold = 1'b0; stray_en = 1'b0;
    n_rst = 1'b1; start = 1'b0;
    cfg_width = '0; cfg_height = '0; cfg_rd_base = '0; cfg_wr_base = '0; cfg_filter = '0;
    test_reset();
    test_basic();
    test_min_frame();
    test_invalid_cfg();
    test_back_to_back();
    test_backpressure();
    test_reset_midpass();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
